link_serial_responder: RTL

Externally clocked responder for the Game Boy–style link-port serial protocol. The remote partner drives SCK. This block shifts a byte out on SO and shifts a byte in from SI, one bit per SCK period. It drives its pins through `port_if`-style direction controls, so SCK and SI are always inputs and SO is an output only while enabled. Core logic hands in transmit bytes and receives completed bytes on the system clock.

---
 rtl/link_serial_responder_if.sv | 22 ++
 rtl/link_serial_responder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/link_serial_responder_if.sv
// Core-side transmit/receive handshake bundle for link_serial_responder.
// Latency: none, wires only. Backpressure: tx uses valid/ready; rx has none (pulse only).
// Signals: tx_data/tx_valid (core->responder), tx_ready, rx_data, rx_valid (responder->core).
interface link_serial_responder_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  // master: core logic that supplies tx bytes and consumes rx bytes
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  // slave: the responder itself
  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/link_serial_responder.sv
// Externally clocked link-port serial responder: shifts a byte out on SO / in on SI per SCK period.
// Latency: SCK pin edge to detect 3 clk, SO update on the detect edge, last rise to rx_valid 1 clk.
// Backpressure: tx via one-entry holding register (tx_ready = empty); rx has none, unread bytes are overwritten.
// Ports: clk, reset (sync, high), enable; link_sck_in/link_si_in raw pins; link_so_out + direction
//        controls link_so_dir/link_sck_dir; core (tx/rx handshake interface); busy; abort pulse.
package pocket;
  typedef enum logic {DIR_IN = 1'b0, DIR_OUT = 1'b1} dir_e;
endpackage

module link_serial_responder #(
  parameter logic [7:0] IDLE_BYTE      = 8'hFF,
  parameter int         TIMEOUT_CYCLES = 65536
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     link_sck_in,
  input  logic                     link_si_in,
  output logic                     link_so_out,
  output pocket::dir_e             link_so_dir,
  output pocket::dir_e             link_sck_dir,
  link_serial_responder_if.slave   core,
  output logic                     busy,
  output logic                     abort
);

  localparam int IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  logic          sck_s1, sck_s2, sck_s3;
  logic          si_s1, si_s2;
  logic          fall, rise;
  logic [7:0]    hold, sh, rx_data_q, load_byte;
  logic          hold_full, rx_valid_q, abort_q, so_q;
  logic [2:0]    bit_cnt;
  logic [IW-1:0] idle_cnt;
  logic          tx_accept;

  // SCK and SI go through identical two-stage synchronisers so SI is
  // sampled in the same cycle the rising SCK edge becomes visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s1 <= 1'b1;
      sck_s2 <= 1'b1;
      sck_s3 <= 1'b1;
      si_s1  <= 1'b1;
      si_s2  <= 1'b1;
    end else begin
      sck_s1 <= link_sck_in;
      sck_s2 <= sck_s1;
      sck_s3 <= sck_s2;
      si_s1  <= link_si_in;
      si_s2  <= si_s1;
    end
  end

  assign fall      = sck_s3 & ~sck_s2;
  assign rise      = ~sck_s3 & sck_s2;
  assign load_byte = hold_full ? hold : IDLE_BYTE;
  assign tx_accept = core.tx_valid & ~hold_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= 8'h00;
      hold_full  <= 1'b0;
      sh         <= 8'h00;
      bit_cnt    <= 3'd0;
      idle_cnt   <= '0;
      so_q       <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;

      // Accept only into an empty register, so it never collides with the
      // byte-start load below (which only clears a full register).
      if (tx_accept) begin
        hold      <= core.tx_data;
        hold_full <= 1'b1;
      end

      if (!enable) begin
        bit_cnt  <= 3'd0;
        idle_cnt <= '0;
        so_q     <= 1'b0;
      end else begin
        if (fall) begin
          if (bit_cnt == 3'd0) begin
            sh   <= load_byte;
            so_q <= load_byte[7];
            if (hold_full) hold_full <= 1'b0;
          end else begin
            so_q <= sh[7];
          end
        end

        if (rise) begin
          sh      <= {sh[6:0], si_s2};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_q  <= {sh[6:0], si_s2};
            rx_valid_q <= 1'b1;
          end
        end

        // Watchdog only runs mid-byte and only when no edge arrived, so its
        // bit_cnt/so writes never overlap the edge updates above.
        if (fall || rise || bit_cnt == 3'd0) begin
          idle_cnt <= '0;
        end else if (idle_cnt == IDLE_LAST) begin
          idle_cnt <= '0;
          bit_cnt  <= 3'd0;
          so_q     <= 1'b1;
          abort_q  <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end
    end
  end

  assign link_so_out   = so_q;
  assign link_so_dir   = (enable && !reset) ? pocket::DIR_OUT : pocket::DIR_IN;
  assign link_sck_dir  = pocket::DIR_IN;
  assign busy          = (bit_cnt != 3'd0);
  assign abort         = abort_q;
  assign core.tx_ready = ~hold_full;
  assign core.rx_data  = rx_data_q;
  assign core.rx_valid = rx_valid_q;

endmodule
